// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding and datapath mux encodings for the multicycle control FSM.
// Rev 1.0
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] c_SRCB_REG   = 2'b00;
  localparam logic [1:0] c_SRCB_IMM   = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR  = 2'b10;

  localparam logic [1:0] c_RES_ALUOUT = 2'b00;
  localparam logic [1:0] c_RES_RDATA  = 2'b01;
  localparam logic [1:0] c_RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: saturating memory wait-state counter with a bounded timeout compare.
// Rev 1.0
`default_nettype none

module mc_wait_timer #(
  parameter int WAIT_LIMIT = 16,
  parameter int WCNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_count,
  input  logic i_clear,
  output logic o_timeout
);

  localparam logic [WCNT_W-1:0] c_LIMIT = WCNT_W'(WAIT_LIMIT);

  logic [WCNT_W-1:0] r_cnt;

  assign o_timeout = (WAIT_LIMIT != 0) && i_count && (r_cnt == c_LIMIT);

  // A timeout restarts the count so a stalled FETCH does not fire every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_count || i_clear || o_timeout) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + WCNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multicycle ARM main control FSM sequencing ALU, unified memory and register file.
// Rev 1.0
`default_nettype none

module mc_main_fsm
  import mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int WCNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       next_pc,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       reg_write,
  output logic       mem_write,
  output logic       branch,
  output logic       flag_write,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state_o
);

  state_t r_state;
  state_t w_next;
  logic   w_count;
  logic   w_timeout;
  logic   w_reg_write;
  logic   w_mem_write;
  logic   w_branch;
  logic   w_flag_write;
  logic   w_unused;

  assign w_unused = &{1'b0, funct[2:1]};
  assign w_count  = is_wait_state(r_state) && !mem_ready;

  mc_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .WCNT_W     (WCNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_count   (w_count),
    .i_clear   (w_next != r_state),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    ir_write     = 1'b0;
    next_pc      = 1'b0;
    adr_src      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = c_SRCB_REG;
    result_src   = c_RES_ALUOUT;
    alu_op       = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_flag_write = 1'b0;
    illegal      = 1'b0;
    bus_error    = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = c_SRCB_FOUR;
        result_src = c_RES_ALU;
        ir_write   = mem_ready;
        next_pc    = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = c_SRCB_FOUR;
        result_src = c_RES_ALU;
        if (!cond_ex) begin
          w_next = S_FETCH;
        end else begin
          case (op)
            OP_MEM:  w_next = S_MEMADR;
            OP_DP:   w_next = funct[5] ? S_EXECI : S_EXECR;
            OP_BR:   w_next = S_BRANCH;
            default: begin
              w_next  = S_FETCH;
              illegal = 1'b1;
            end
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_b = c_SRCB_IMM;
        w_next    = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = c_RES_RDATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        alu_op       = 1'b1;
        alu_src_b    = c_SRCB_REG;
        w_flag_write = funct[0];
        w_next       = S_ALUWB;
      end
      S_EXECI: begin
        alu_op       = 1'b1;
        alu_src_b    = c_SRCB_IMM;
        w_flag_write = funct[0];
        w_next       = S_ALUWB;
      end
      S_ALUWB: begin
        result_src  = c_RES_ALUOUT;
        // Compare-class ops (funct[4:3] = 10) only touch the flags.
        w_reg_write = (funct[4:3] != 2'b10);
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = c_SRCB_IMM;
        result_src = c_RES_ALU;
        w_branch   = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next      = S_FETCH;
      bus_error   = 1'b1;
      w_mem_write = 1'b0;
    end
  end

  assign reg_write  = w_reg_write  & cond_ex;
  assign mem_write  = w_mem_write  & cond_ex;
  assign branch     = w_branch     & cond_ex;
  assign flag_write = w_flag_write & cond_ex;
  assign state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: directed and randomized checks of mc_main_fsm against an instruction-plan model.
// Rev 1.0
`default_nettype none

module tb_mc_main_fsm;

  localparam int LIM = 4;

  logic       clk;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       cond_ex;
  logic       mem_ready;
  logic       ir_write, next_pc, adr_src, alu_src_a, alu_op;
  logic [1:0] alu_src_b, result_src;
  logic       reg_write, mem_write, branch, flag_write, illegal, bus_error;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  // Model: current state, consecutive wait cycles, and the states still owed by the instruction.
  int m_state;
  int m_wait;
  int plan[$];

  logic [1:0] rop;
  logic [5:0] rf;
  logic       rc, rr;
  int         burst;
  int         add_tr[4];

  mc_main_fsm #(.WAIT_LIMIT(LIM), .WCNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .cond_ex(cond_ex),
    .mem_ready(mem_ready), .ir_write(ir_write), .next_pc(next_pc),
    .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .reg_write(reg_write),
    .mem_write(mem_write), .branch(branch), .flag_write(flag_write),
    .illegal(illegal), .bus_error(bus_error), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic is_wait(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic logic timeout_now();
    return (LIM != 0) && is_wait(m_state) && !mem_ready && (m_wait == LIM);
  endfunction

  function automatic logic [15:0] expect_out();
    logic irw = 0, npc = 0, adr = 0, sa = 0, aop = 0;
    logic rw = 0, mw = 0, br = 0, fw = 0, ill = 0, be = 0;
    logic [1:0] sb = 2'b00, rs = 2'b00;
    case (m_state)
      0: begin sa = 1; sb = 2'b10; rs = 2'b10; irw = mem_ready; npc = mem_ready; end
      1: begin sa = 1; sb = 2'b10; rs = 2'b10; ill = cond_ex && (op == 2'b11); end
      2: sb = 2'b01;
      3: adr = 1;
      4: begin rs = 2'b01; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin aop = 1; sb = 2'b00; fw = funct[0]; end
      7: begin aop = 1; sb = 2'b01; fw = funct[0]; end
      8: begin rs = 2'b00; rw = (funct[4:3] != 2'b10); end
      9: begin sb = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    if (timeout_now()) begin be = 1; mw = 0; end
    rw = rw & cond_ex; mw = mw & cond_ex; br = br & cond_ex; fw = fw & cond_ex;
    return {irw, npc, adr, sa, sb, rs, aop, rw, mw, br, fw, ill, be};
  endfunction

  function automatic logic [15:0] obs_out();
    return {ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src, alu_op,
            reg_write, mem_write, branch, flag_write, illegal, bus_error};
  endfunction

  task automatic drive(input logic [1:0] o, input logic [5:0] f, input logic c, input logic r);
    op = o; funct = f; cond_ex = c; mem_ready = r;
    #4;
  endtask

  task automatic chk_model();
    chk("state", 32'(state_o), 32'(m_state));
    chk("outputs", 32'(obs_out()), 32'(expect_out()));
  endtask

  function automatic int take_plan();
    if (plan.size() > 0) return plan.pop_front();
    return 0;
  endfunction

  task automatic adv();
    logic to;
    int   nxt;
    to = timeout_now();
    if (to) begin
      plan.delete();
      nxt = 0;
    end else begin
      case (m_state)
        0: nxt = mem_ready ? 1 : 0;
        1: begin
          plan.delete();
          if (cond_ex) begin
            if (op == 2'b01) begin
              if (funct[0]) plan = '{2, 3, 4};
              else          plan = '{2, 5};
            end else if (op == 2'b00) begin
              plan.push_back(funct[5] ? 7 : 6);
              plan.push_back(8);
            end else if (op == 2'b10) begin
              plan.push_back(9);
            end
          end
          nxt = take_plan();
        end
        3, 5: nxt = mem_ready ? take_plan() : m_state;
        default: nxt = take_plan();
      endcase
    end
    if (!is_wait(m_state) || mem_ready || to || nxt != m_state) m_wait = 0;
    else if (m_wait < 255) m_wait++;
    m_state = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] o, input logic [5:0] f, input logic c, input logic r);
    drive(o, f, c, r);
    chk_model();
    adv();
  endtask

  initial begin
    add_tr = '{0, 1, 6, 8};
    reset = 1'b1; op = 2'b00; funct = 6'd0; cond_ex = 1'b0; mem_ready = 1'b0;
    m_state = 0; m_wait = 0; burst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_model();
    reset = 1'b0;

    // ADD register: FETCH, DECODE, EXECR, ALUWB
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 6'b001000, 1'b1, 1'b1);
      chk("add_trace", 32'(state_o), 32'(add_tr[i]));
      chk_model();
      adv();
    end
    chk("add_done", 32'(state_o), 32'd0);

    // LDR with three wait cycles in MEMRD
    step(2'b01, 6'b011001, 1'b1, 1'b1);
    step(2'b01, 6'b011001, 1'b1, 1'b1);
    step(2'b01, 6'b011001, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b01, 6'b011001, 1'b1, 1'b0);
    step(2'b01, 6'b011001, 1'b1, 1'b1);
    drive(2'b01, 6'b011001, 1'b1, 1'b1);
    chk("ldr_wb_regwrite", 32'(reg_write), 32'd1);
    chk_model();
    adv();
    chk("ldr_done", 32'(state_o), 32'd0);

    // STR squashed by cond_ex = 0
    step(2'b01, 6'b011000, 1'b1, 1'b1);
    step(2'b01, 6'b011000, 1'b0, 1'b1);
    chk("str_squash", 32'(state_o), 32'd0);

    // CMP immediate
    step(2'b00, 6'b110101, 1'b1, 1'b1);
    step(2'b00, 6'b110101, 1'b1, 1'b1);
    drive(2'b00, 6'b110101, 1'b1, 1'b1);
    chk("cmp_flag_write", 32'(flag_write), 32'd1);
    chk_model();
    adv();
    drive(2'b00, 6'b110101, 1'b1, 1'b1);
    chk("cmp_no_regwrite", 32'(reg_write), 32'd0);
    chk_model();
    adv();

    // STR timing out in MEMWR
    step(2'b01, 6'b011000, 1'b1, 1'b1);
    step(2'b01, 6'b011000, 1'b1, 1'b1);
    step(2'b01, 6'b011000, 1'b1, 1'b1);
    for (int i = 0; i < LIM; i++) step(2'b01, 6'b011000, 1'b1, 1'b0);
    drive(2'b01, 6'b011000, 1'b1, 1'b0);
    chk("timeout_bus_error", 32'(bus_error), 32'd1);
    chk("timeout_no_write", 32'(mem_write), 32'd0);
    chk_model();
    adv();
    chk("timeout_to_fetch", 32'(state_o), 32'd0);

    // STR with mem_ready on the limit cycle
    step(2'b01, 6'b011000, 1'b1, 1'b1);
    step(2'b01, 6'b011000, 1'b1, 1'b1);
    step(2'b01, 6'b011000, 1'b1, 1'b1);
    for (int i = 0; i < LIM; i++) step(2'b01, 6'b011000, 1'b1, 1'b0);
    drive(2'b01, 6'b011000, 1'b1, 1'b1);
    chk("limit_ready_no_err", 32'(bus_error), 32'd0);
    chk("limit_ready_write", 32'(mem_write), 32'd1);
    chk_model();
    adv();

    // Illegal op
    step(2'b11, 6'b000000, 1'b1, 1'b1);
    drive(2'b11, 6'b000000, 1'b1, 1'b1);
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk_model();
    adv();
    chk("illegal_to_fetch", 32'(state_o), 32'd0);

    // Asynchronous reset while stalled in MEMRD
    step(2'b01, 6'b011001, 1'b1, 1'b1);
    step(2'b01, 6'b011001, 1'b1, 1'b1);
    step(2'b01, 6'b011001, 1'b1, 1'b1);
    drive(2'b01, 6'b011001, 1'b1, 1'b0);
    chk_model();
    reset = 1'b1;
    #1;
    plan.delete(); m_state = 0; m_wait = 0;
    chk("async_reset_state", 32'(state_o), 32'd0);
    chk("async_reset_outs", 32'(obs_out()), 32'(expect_out()));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized instruction stream with occasional long memory stalls
    for (int i = 0; i < 600; i++) begin
      if (m_state == 0) begin
        rop = 2'($urandom_range(0, 3));
        rf  = 6'($urandom);
      end
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(3, 7);
      if (burst > 0) begin
        rr = 1'b0;
        burst--;
      end else begin
        rr = ($urandom_range(0, 3) != 0);
      end
      rc = ($urandom_range(0, 7) != 0);
      step(rop, rf, rc, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
